// File: rtl/uart_rx32.sv
// 8N1 UART receiver assembling four consecutive bytes into one 32-bit word.
// First byte lands in data[7:0]; an inter-byte timeout drops a partial word.
module uart_rx32 #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [31:0] data,
  output logic        valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int TO_CYCLES    = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam int TW           = $clog2(TO_CYCLES + 1);

  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TO_M1   = TW'(TO_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t        state;
  logic          rx_m, rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [23:0]   word;
  logic [1:0]    byte_cnt;
  logic [TW-1:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: synchroniser resets to the idle-high level so reset release never looks like a start bit.
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      word      <= '0;
      byte_cnt  <= '0;
      idle_cnt  <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      // NOTE: non-blocking everywhere so every branch below sees last cycle's state.
      rx_m      <= rx;
      rx_s      <= rx_m;
      valid     <= 1'b0;
      frame_err <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            // A start edge beats a simultaneous timeout.
            cnt      <= HALF_M1;
            idle_cnt <= '0;
            state    <= START;
          end else if (byte_cnt != 2'd0) begin
            if (idle_cnt == TO_M1) begin
              frame_err <= 1'b1;
              byte_cnt  <= '0;
              idle_cnt  <= '0;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end else begin
            idle_cnt <= '0;
          end
        end

        START: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!rx_s) begin
            cnt     <= FULL_M1;
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            state <= IDLE;
          end
        end

        DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            shreg   <= {rx_s, shreg[7:1]};
            cnt     <= FULL_M1;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end
        end

        STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rx_s) begin
            case (byte_cnt)
              2'd0:    word[7:0]   <= shreg;
              2'd1:    word[15:8]  <= shreg;
              2'd2:    word[23:16] <= shreg;
              default: begin
                data  <= {shreg, word};
                valid <= 1'b1;
              end
            endcase
            byte_cnt <= byte_cnt + 2'd1;
            state    <= IDLE;
          end else begin
            frame_err <= 1'b1;
            byte_cnt  <= '0;
            state     <= BREAK;
          end
        end

        BREAK: begin
          if (rx_s) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE) || (byte_cnt != 2'd0);

endmodule

// File: tb/tb_uart_rx32.sv
// Directed bench for uart_rx32 at 10 clocks per bit: word vectors from a table
// plus hand-written glitch, break, timeout and mid-frame reset sequences.
module tb_uart_rx32;

  localparam int CPB = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [31:0] data;
  logic        valid, frame_err, busy;

  uart_rx32 #(
    .CLK_FREQ    (50_000_000),
    .BAUD        (5_000_000),
    .TIMEOUT_BITS(20)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail = 0;
  int   valid_cnt = 0;
  int   ferr_cnt = 0;
  int   overlap_cnt = 0;
  int   wide_cnt = 0;
  logic valid_q = 1'b0;

  // Pulse monitor, sampled on the falling edge away from DUT updates.
  always @(negedge clk) begin
    if (valid) valid_cnt++;
    if (frame_err) ferr_cnt++;
    if (valid && frame_err) overlap_cnt++;
    if (valid && valid_q) wide_cnt++;
    valid_q = valid;
  end

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
  endtask

  // Behaves like the 32-bit transmitter: four back-to-back frames, byte 0 first.
  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
  endtask

  task automatic check_word(input string name, input int v0, input int f0,
                            input logic [31:0] exp);
    tick(3 * CPB);
    check({name, " valid pulses"}, 32'(valid_cnt - v0), 32'd1);
    check({name, " frame_err pulses"}, 32'(ferr_cnt - f0), 32'd0);
    check({name, " data"}, data, exp);
    check({name, " busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int v0, f0;

    vecs[0] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 32'hDEADBEEF};
    vecs[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFFFFFF};
    vecs[3] = '{8'h01, 8'h80, 8'h7F, 8'hFE, 32'hFE7F8001};

    rst = 1'b1;
    rx  = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(4 * CPB);
    check("reset data", data, 32'd0);
    check("reset valid", 32'(valid_cnt), 32'd0);
    check("reset frame_err", 32'(ferr_cnt), 32'd0);
    check("reset busy", 32'(busy), 32'd0);

    for (int i = 0; i < 4; i++) begin
      v0 = valid_cnt;
      f0 = ferr_cnt;
      send_byte(vecs[i].b0, 1'b1);
      send_byte(vecs[i].b1, 1'b1);
      send_byte(vecs[i].b2, 1'b1);
      send_byte(vecs[i].b3, 1'b1);
      check_word($sformatf("vec%0d", i), v0, f0, vecs[i].exp);
    end

    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_word(32'h12345678);
    check_word("loopback", v0, f0, 32'h12345678);

    // Short low glitch: false start, nothing reported, data held.
    v0 = valid_cnt;
    f0 = ferr_cnt;
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(3 * CPB);
    check("glitch valid", 32'(valid_cnt - v0), 32'd0);
    check("glitch frame_err", 32'(ferr_cnt - f0), 32'd0);
    check("glitch data", data, 32'h12345678);
    check("glitch busy", 32'(busy), 32'd0);

    // Stop bit low, line held low, then a clean word.
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_byte(8'h55, 1'b0);
    tick(50);
    rx = 1'b1;
    tick(2 * CPB);
    check("break frame_err", 32'(ferr_cnt - f0), 32'd1);
    check("break busy", 32'(busy), 32'd0);
    send_word(32'h04030201);
    tick(3 * CPB);
    check("break frame_err total", 32'(ferr_cnt - f0), 32'd1);
    check("break valid", 32'(valid_cnt - v0), 32'd1);
    check("break data", data, 32'h04030201);

    // 19 idle bit-times between bytes stays inside the timeout.
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    check("gap busy", 32'(busy), 32'd1);
    tick(19 * CPB);
    send_byte(8'hCC, 1'b1);
    send_byte(8'hDD, 1'b1);
    check_word("short gap", v0, f0, 32'hDDCCBBAA);

    // 21 idle bit-times drops the partial word.
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    tick(21 * CPB);
    check("timeout frame_err", 32'(ferr_cnt - f0), 32'd1);
    check("timeout busy", 32'(busy), 32'd0);
    send_word(32'h44332211);
    tick(3 * CPB);
    check("timeout valid", 32'(valid_cnt - v0), 32'd1);
    check("timeout frame_err total", 32'(ferr_cnt - f0), 32'd1);
    check("timeout data", data, 32'h44332211);

    // Reset in the middle of the second byte.
    send_byte(8'hAA, 1'b1);
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(3 * CPB);
    v0 = valid_cnt;
    f0 = ferr_cnt;
    rst = 1'b1;
    tick(1);
    check("midreset data", data, 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset valid", 32'(valid), 32'd0);
    check("midreset frame_err", 32'(frame_err), 32'd0);
    tick(1);
    rst = 1'b0;
    tick(3 * CPB);
    check("midreset no pulses", 32'(valid_cnt - v0 + ferr_cnt - f0), 32'd0);
    send_word(32'hCAFEF00D);
    check_word("after reset", v0, f0, 32'hCAFEF00D);

    check("valid/frame_err overlap", 32'(overlap_cnt), 32'd0);
    check("valid wider than 1", 32'(wide_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
